// File: rtl/bcd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : bcd_pkg
// Brief   : Shared BCD / decimal one-hot types, widths and serializer states.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_MAX = 9;
    localparam int BCD_W   = 4;
    localparam int DEC_W   = 10;

    typedef logic [BCD_W-1:0] bcd_digit_t;
    typedef logic [DEC_W-1:0] dec_onehot_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : bcd_digit_decode
// Brief   : Combinational single-digit BCD to 1-of-10 decoder with an
//           invalid-code flag. Codes 10..15 give an all-zero one-hot.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module bcd_digit_decode
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [DEC_W-1:0] o_onehot,
    output logic             o_err
);

    // Compare against every decimal value; invalid codes match none of them.
    always_comb begin
        o_onehot = '0;
        o_err    = (i_digit > BCD_W'(BCD_MAX));
        for (int k = 0; k < DEC_W; k++) begin
            o_onehot[k] = (i_digit == BCD_W'(k));
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_onehot_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : bcd_onehot_serializer
// Brief   : Accepts a packed multi-digit BCD word and emits it MSD first as a
//           registered 1-of-10 code, one digit per out_valid/out_ready beat.
//           Optional leading-zero blanking and active-low output.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module bcd_onehot_serializer
    import bcd_pkg::*;
#(
    parameter  int NUM_DIGITS    = 4,
    parameter  int BLANK_LEADING = 0,
    parameter  int ACTIVE_LOW    = 0,
    localparam int IDXW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_bcd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DEC_W-1:0]        out_y,
    output logic [IDXW-1:0]         out_idx,
    output logic                    out_last,
    output logic                    out_err,
    output logic                    err_sticky
);

    localparam logic [IDXW-1:0] c_msd_idx    = IDXW'(NUM_DIGITS - 1);
    localparam dec_onehot_t     c_y_inactive = (ACTIVE_LOW != 0) ? {DEC_W{1'b1}} : {DEC_W{1'b0}};

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [4*NUM_DIGITS-1:0]   r_word;
    logic [IDXW-1:0]           r_idx;
    logic                      r_seen_nz;
    dec_onehot_t               r_y;
    logic                      r_last;
    logic                      r_err;
    logic                      r_sticky;

    logic                      w_accept;
    logic                      w_advance;
    logic                      w_load;
    logic [IDXW-1:0]           w_pos;
    bcd_digit_t                w_digit;
    bcd_digit_t                w_digits [NUM_DIGITS];
    logic                      w_seen_prev;
    logic                      w_blank;
    dec_onehot_t               w_onehot;
    logic                      w_derr;
    dec_onehot_t               w_y_pos;
    dec_onehot_t               w_y_out;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
            assign w_digits[g] = r_word[BCD_W*g +: BCD_W];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, accept/advance strobes and in_ready.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (r_idx == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The beat to be loaded: the incoming MSD on accept, else the next lower
    // digit of the captured word.
    assign w_load      = w_accept | w_advance;
    assign w_pos       = (r_state == IDLE) ? c_msd_idx : (r_idx - 1'b1);
    assign w_digit     = (r_state == IDLE) ? in_bcd[BCD_W*NUM_DIGITS-1 -: BCD_W] : w_digits[w_pos];
    assign w_seen_prev = (r_state == IDLE) ? 1'b0 : r_seen_nz;

    bcd_digit_decode u_decode (
        .i_digit  (w_digit),
        .o_onehot (w_onehot),
        .o_err    (w_derr)
    );

    // Leading-zero blanking never applies to digit 0; invalid codes are
    // nonzero and so end the leading run.
    assign w_blank = (BLANK_LEADING != 0) && !w_seen_prev && (w_digit == '0) && (w_pos != '0);
    assign w_y_pos = w_blank ? '0 : w_onehot;
    assign w_y_out = (ACTIVE_LOW != 0) ? ~w_y_pos : w_y_pos;

    // Word capture and beat registers; everything holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word    <= '0;
            r_idx     <= '0;
            r_seen_nz <= 1'b0;
            r_y       <= c_y_inactive;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
            r_sticky  <= 1'b0;
        end else if (w_load) begin
            if (w_accept) begin
                r_word <= in_bcd;
            end
            r_idx     <= w_pos;
            r_seen_nz <= w_seen_prev | (w_digit != '0);
            r_y       <= w_y_out;
            r_last    <= (w_pos == '0);
            r_err     <= w_derr;
            r_sticky  <= (w_accept ? 1'b0 : r_sticky) | w_derr;
        end
    end

    assign out_valid  = (r_state == SHIFT);
    assign out_y      = r_y;
    assign out_idx    = r_idx;
    assign out_last   = r_last;
    assign out_err    = r_err;
    assign err_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_bcd_onehot_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_bcd_onehot_serializer
// Brief   : Self-checking bench for bcd_onehot_serializer. Three instances:
//           default (4 digits), leading-zero blanking, and 1-digit active-low.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_bcd_onehot_serializer;

    logic clk = 1'b0;
    logic rst;

    logic        v0, or0, ir0, ov0, last0, err0, st0;
    logic [15:0] b0;
    logic [9:0]  y0;
    logic [1:0]  idx0;

    logic        v1, or1, ir1, ov1, last1, err1, st1;
    logic [15:0] b1;
    logic [9:0]  y1;
    logic [1:0]  idx1;

    logic        v2, or2, ir2, ov2, last2, err2, st2;
    logic [3:0]  b2;
    logic [9:0]  y2;
    logic [0:0]  idx2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bcd_onehot_serializer #(.NUM_DIGITS(4), .BLANK_LEADING(0), .ACTIVE_LOW(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .in_bcd(b0),
        .out_valid(ov0), .out_ready(or0), .out_y(y0), .out_idx(idx0),
        .out_last(last0), .out_err(err0), .err_sticky(st0)
    );

    bcd_onehot_serializer #(.NUM_DIGITS(4), .BLANK_LEADING(1), .ACTIVE_LOW(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_bcd(b1),
        .out_valid(ov1), .out_ready(or1), .out_y(y1), .out_idx(idx1),
        .out_last(last1), .out_err(err1), .err_sticky(st1)
    );

    bcd_onehot_serializer #(.NUM_DIGITS(1), .BLANK_LEADING(0), .ACTIVE_LOW(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_bcd(b2),
        .out_valid(ov2), .out_ready(or2), .out_y(y2), .out_idx(idx2),
        .out_last(last2), .out_err(err2), .err_sticky(st2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: digit value by arithmetic, blanking from "all higher digits are zero".
    function automatic logic [9:0] model_y(input int word, input int pos, input bit blank, input bit al);
        int          digit;
        int          higher;
        logic [9:0]  y;
        digit  = (word >> (4 * pos)) & 15;
        higher = word >> (4 * (pos + 1));
        y      = '0;
        if (digit <= 9 && !(blank && pos != 0 && digit == 0 && higher == 0)) begin
            y = 10'(1 << digit);
        end
        return al ? ~y : y;
    endfunction

    task automatic sample(input int d, output logic [9:0] y, output int idx, output logic last,
                          output logic err, output logic st, output logic ov, output logic ir);
        case (d)
            0: begin y = y0; idx = int'(idx0); last = last0; err = err0; st = st0; ov = ov0; ir = ir0; end
            1: begin y = y1; idx = int'(idx1); last = last1; err = err1; st = st1; ov = ov1; ir = ir1; end
            default: begin y = y2; idx = int'(idx2); last = last2; err = err2; st = st2; ov = ov2; ir = ir2; end
        endcase
    endtask

    task automatic drive_in(input int d, input logic v, input logic [15:0] w);
        case (d)
            0: begin v0 = v; b0 = w; end
            1: begin v1 = v; b1 = w; end
            default: begin v2 = v; b2 = w[3:0]; end
        endcase
    endtask

    task automatic drive_rdy(input int d, input logic r);
        case (d)
            0: or0 = r;
            1: or1 = r;
            default: or2 = r;
        endcase
    endtask

    // Send one word to instance d and check every cycle of every beat,
    // including stalled cycles. poke offers another word during the
    // last-beat handshake, which must be ignored.
    task automatic run_word(input int d, input int word, input bit rnd, input bit poke);
        int          n;
        bit          blank, al;
        logic [9:0]  y;
        int          idx;
        logic        last, err, st, ov, ir;
        bit          sticky_exp;
        int          digit, stalls, waited;
        bit          done;
        logic        r;
        n     = (d == 2) ? 1 : 4;
        blank = (d == 1);
        al    = (d == 2);
        word  = word & ((1 << (4 * n)) - 1);
        waited = 0;
        sample(d, y, idx, last, err, st, ov, ir);
        while (!ir && waited < 20) begin
            @(negedge clk);
            waited++;
            sample(d, y, idx, last, err, st, ov, ir);
        end
        check("accept_in_ready", 32'(ir), 32'd1);
        if (!ir) return;
        drive_in(d, 1'b1, 16'(word));
        @(negedge clk);
        drive_in(d, 1'b0, 16'h0);
        sticky_exp = 1'b0;
        for (int pos = n - 1; pos >= 0; pos--) begin
            digit      = (word >> (4 * pos)) & 15;
            sticky_exp = sticky_exp | (digit > 9);
            stalls     = 0;
            done       = 1'b0;
            while (!done) begin
                sample(d, y, idx, last, err, st, ov, ir);
                check("beat_valid", 32'(ov), 32'd1);
                check("beat_in_ready", 32'(ir), 32'd0);
                check("beat_y", 32'(y), 32'(model_y(word, pos, blank, al)));
                check("beat_idx", 32'(idx), 32'(pos));
                check("beat_last", 32'(last), 32'(pos == 0));
                check("beat_err", 32'(err), 32'(digit > 9));
                check("beat_sticky", 32'(st), 32'(sticky_exp));
                r = (rnd && stalls < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!r) stalls++;
                drive_rdy(d, r);
                if (poke && pos == 0 && r) drive_in(d, 1'b1, 16'h9999);
                @(negedge clk);
                drive_in(d, 1'b0, 16'h0);
                if (r) done = 1'b1;
            end
        end
        sample(d, y, idx, last, err, st, ov, ir);
        check("idle_valid", 32'(ov), 32'd0);
        check("idle_in_ready", 32'(ir), 32'd1);
        check("idle_sticky", 32'(st), 32'(sticky_exp));
    endtask

    function automatic int rand_word();
        int w;
        w = 0;
        for (int i = 0; i < 4; i++) begin
            int dg;
            dg = int'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) dg = 0;
            else if (dg > 9 && $urandom_range(0, 2) != 0) dg = dg - 10;
            w = (w << 4) | dg;
        end
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        v0 = 0; b0 = 0; or0 = 1;
        v1 = 0; b1 = 0; or1 = 1;
        v2 = 0; b2 = 0; or2 = 1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_valid", 32'(ov0), 32'd0);
        check("rst_y", 32'(y0), 32'h000);
        check("rst_idx", 32'(idx0), 32'd0);
        check("rst_last", 32'(last0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_sticky", 32'(st0), 32'd0);
        check("rst_y_active_low", 32'(y2), 32'h3FF);
        check("rst_valid_1digit", 32'(ov2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic words, error digit, blanking
        run_word(0, 32'h1907, 1'b0, 1'b0);
        run_word(0, 32'h0A05, 1'b0, 1'b0);
        run_word(1, 32'h0000, 1'b0, 1'b0);
        run_word(1, 32'h0040, 1'b0, 1'b0);
        run_word(1, 32'h0B00, 1'b0, 1'b0);

        // Random back-pressure and random words
        for (int i = 0; i < 25; i++) begin
            run_word(0, rand_word(), 1'b1, (i % 3) == 0);
            run_word(1, rand_word(), 1'b1, 1'b0);
            run_word(2, int'($urandom_range(0, 15)), 1'b1, 1'b0);
        end

        // Reset during the idx-2 beat aborts the word
        @(negedge clk);
        or0 = 1'b1;
        drive_in(0, 1'b1, 16'h1234);
        @(negedge clk);
        drive_in(0, 1'b0, 16'h0);
        check("rst_mid_beat3_idx", 32'(idx0), 32'd3);
        @(negedge clk);
        check("rst_mid_beat2_idx", 32'(idx0), 32'd2);
        check("rst_mid_beat2_y", 32'(y0), 32'h004);
        rst = 1'b1;
        #1;
        check("rst_mid_abort_valid", 32'(ov0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_no_beat", 32'(ov0), 32'd0);
        end
        run_word(0, 32'h5678, 1'b0, 1'b0);

        // Single-digit active-low
        run_word(2, 32'h3, 1'b0, 1'b0);
        run_word(2, 32'hC, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
